decoder_n_scan: RTL and testbench

- Parametrised, registered successor to the team's 3-to-8 decoder, generalised to an SEL_W-to-2^SEL_W decoder with selectable output polarity.
- Keeps the three-pin gating enable: en[0] active-high, en[1] and en[2] active-low.
- Adds a scan mode: an internal dwell counter walks a one-hot select across all outputs. Used for multiplexed display digit drive and round-robin strobes.
- Sits between control logic and external select lines.

---
 rtl/decoder_n_scan.sv | 97 +++++++++
 tb/tb_decoder_n_scan.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/decoder_n_scan.sv
// Registered SEL_W-to-2^SEL_W decoder with three-pin gate and polarity select.
// Scan mode walks the selected output round-robin, holding each index dwell+1 cycles.
module decoder_n_scan #(
    parameter int SEL_W      = 3,
    parameter int ACTIVE_LOW = 1,
    parameter int DWELL_W    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [SEL_W-1:0]      in_i,
    input  logic [2:0]            en_i,
    input  logic                  mode_i,
    input  logic [DWELL_W-1:0]    dwell_i,
    input  logic                  load_i,
    output logic [(1<<SEL_W)-1:0] out_o,
    output logic [SEL_W-1:0]      idx_o,
    output logic                  wrap_o
);
    // state  | meaning
    // IDLE   | gate closed, every output inactive, idx retained
    // DIRECT | out follows decode(in) with one cycle latency
    // SCAN   | index advances after dwell+1 cycles, load reloads from in

    localparam int N = 1 << SEL_W;
    localparam logic [N-1:0] OUT_IDLE = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t               state_q, state_d;
    logic [N-1:0]         out_q, out_d;
    logic [SEL_W-1:0]     idx_q, idx_d;
    logic                 wrap_q, wrap_d;
    logic [DWELL_W-1:0]   cnt_q, cnt_d;
    logic                 gate;

    function automatic logic [N-1:0] decode(input logic [SEL_W-1:0] k);
        logic [N-1:0] oh;
        oh    = '0;
        oh[k] = 1'b1;
        return (ACTIVE_LOW != 0) ? ~oh : oh;
    endfunction

    assign gate = en_i[0] & ~en_i[1] & ~en_i[2];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            out_q   <= OUT_IDLE;
            idx_q   <= '0;
            wrap_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            idx_q   <= idx_d;
            wrap_q  <= wrap_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = IDLE;
        if (gate) state_d = mode_i ? SCAN : DIRECT;
    end

    always_comb begin
        idx_d  = idx_q;
        cnt_d  = '0;
        wrap_d = 1'b0;
        out_d  = OUT_IDLE;
        unique case (state_d)
            IDLE: ;
            DIRECT: begin
                idx_d = in_i;
                out_d = decode(in_i);
            end
            SCAN: begin
                // Entry from another state restarts at in; load beats terminal count.
                if (state_q != SCAN || load_i) begin
                    idx_d = in_i;
                end else if (cnt_q >= dwell_i) begin
                    idx_d  = idx_q + 1'b1;
                    wrap_d = &idx_q;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
                out_d = decode(idx_d);
            end
            default: ;
        endcase
    end

    assign out_o  = out_q;
    assign idx_o  = idx_q;
    assign wrap_o = wrap_q;

endmodule

// File: tb/tb_decoder_n_scan.sv
// Randomised and directed bench for decoder_n_scan against a behavioural model;
// a second instance covers SEL_W=4 with active-high outputs.
module tb_decoder_n_scan;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] in_s = '0;
    logic [2:0] en_s = '0;
    logic       mode_s = 1'b0;
    logic [7:0] dwell_s = '0;
    logic       load_s = 1'b0;
    logic [7:0] out_s;
    logic [2:0] idx_s;
    logic       wrap_s;

    logic [3:0]  in2 = '0;
    logic [2:0]  en2 = '0;
    logic        mode2 = 1'b0;
    logic [7:0]  dwell2 = '0;
    logic        load2 = 1'b0;
    logic [15:0] out2;
    logic [3:0]  idx2;
    logic        wrap2;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    decoder_n_scan dut (
        .clk_i(clk), .rst_i(rst), .in_i(in_s), .en_i(en_s), .mode_i(mode_s),
        .dwell_i(dwell_s), .load_i(load_s), .out_o(out_s), .idx_o(idx_s), .wrap_o(wrap_s)
    );

    decoder_n_scan #(.SEL_W(4), .ACTIVE_LOW(0), .DWELL_W(8)) dut16 (
        .clk_i(clk), .rst_i(rst), .in_i(in2), .en_i(en2), .mode_i(mode2),
        .dwell_i(dwell2), .load_i(load2), .out_o(out2), .idx_o(idx2), .wrap_o(wrap2)
    );

    // Behavioural model: enabled flag, scanning flag, current index and cycles spent on it.
    logic [2:0] m_idx;
    logic [7:0] m_held;
    logic       m_on, m_scan, m_wrap;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_idx <= 3'd0; m_held <= 8'd0; m_on <= 1'b0; m_scan <= 1'b0; m_wrap <= 1'b0;
        end else if (en_s != 3'b001) begin
            m_on <= 1'b0; m_scan <= 1'b0; m_wrap <= 1'b0; m_held <= 8'd0;
        end else if (!mode_s) begin
            m_on <= 1'b1; m_scan <= 1'b0; m_wrap <= 1'b0; m_held <= 8'd0; m_idx <= in_s;
        end else if (!m_scan || load_s) begin
            m_on <= 1'b1; m_scan <= 1'b1; m_wrap <= 1'b0; m_held <= 8'd0; m_idx <= in_s;
        end else if (int'(m_held) >= int'(dwell_s)) begin
            m_wrap <= (m_idx == 3'd7);
            m_idx  <= 3'((int'(m_idx) + 1) % 8);
            m_held <= 8'd0;
        end else begin
            m_wrap <= 1'b0;
            m_held <= m_held + 8'd1;
        end
    end

    function automatic logic [7:0] model_out();
        logic [7:0] sel;
        sel = 8'd1 << m_idx;
        return m_on ? ~sel : 8'hFF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check("out", 32'(out_s), 32'(model_out()));
        check("idx", 32'(idx_s), 32'(m_idx));
        check("wrap", 32'(wrap_s), 32'(m_wrap));
    endtask

    initial begin
        int seq [12] = '{6, 6, 6, 7, 7, 7, 0, 0, 0, 1, 1, 1};
        int k;

        repeat (2) @(posedge clk);
        #1;
        check("rst_out", 32'(out_s), 32'hFF);
        check("rst_idx", 32'(idx_s), 32'd0);
        check("rst_wrap", 32'(wrap_s), 32'd0);
        check("rst_out16", 32'(out2), 32'h0);
        rst = 1'b0;

        // direct decode sweep, then gate closed
        en_s = 3'b001; mode_s = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_s = 3'(i);
            step();
            check("direct_out", 32'(out_s), 32'(8'(~(8'd1 << i))));
        end
        en_s = 3'b110;
        step();
        check("gate_off", 32'(out_s), 32'hFF);

        // scan from 6 with dwell 2
        en_s = 3'b001; mode_s = 1'b1; in_s = 3'd6; dwell_s = 8'd2;
        for (int i = 0; i < 12; i++) begin
            step();
            check("scan_seq", 32'(idx_s), 32'(seq[i]));
            check("scan_wrap", 32'(wrap_s), 32'(i == 6));
        end

        // reload at idx 7 with dwell 0
        dwell_s = 8'd0;
        k = 0;
        while (m_idx != 3'd7 && k < 10) begin step(); k++; end
        check("reach_idx7", 32'(m_idx), 32'd7);
        load_s = 1'b1; in_s = 3'd3;
        step();
        check("reload_idx", 32'(idx_s), 32'd3);
        check("reload_wrap", 32'(wrap_s), 32'd0);
        load_s = 1'b0;
        step();
        check("reload_next", 32'(idx_s), 32'd4);

        // dwell shrink below running count forces advance
        dwell_s = 8'd10; load_s = 1'b1; in_s = 3'd5;
        step();
        load_s = 1'b0;
        repeat (7) step();
        check("shrink_hold", 32'(idx_s), 32'd5);
        dwell_s = 8'd4;
        step();
        check("shrink_adv", 32'(idx_s), 32'd6);
        en_s = 3'b000;
        step();
        check("drop_out", 32'(out_s), 32'hFF);
        en_s = 3'b001; in_s = 3'd2;
        step();
        check("reen_idx", 32'(idx_s), 32'd2);
        repeat (4) step();
        check("reen_hold", 32'(idx_s), 32'd2);
        step();
        check("reen_adv", 32'(idx_s), 32'd3);

        // asynchronous reset mid-scan
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_out", 32'(out_s), 32'hFF);
        check("arst_idx", 32'(idx_s), 32'd0);
        check("arst_wrap", 32'(wrap_s), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // randomised traffic
        for (int i = 0; i < 600; i++) begin
            en_s    = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'b001;
            mode_s  = ($urandom_range(0, 4) != 0);
            in_s    = 3'($urandom);
            dwell_s = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 4));
            load_s  = ($urandom_range(0, 7) == 0);
            step();
        end

        // 16-output active-high variant, dwell 0
        en2 = 3'b001; mode2 = 1'b1; in2 = 4'd0; dwell2 = 8'd0;
        for (int i = 0; i < 40; i++) begin
            step();
            check("v16_idx", 32'(idx2), 32'(i % 16));
            check("v16_out", 32'(out2), 32'(1 << (i % 16)));
            check("v16_wrap", 32'(wrap2), 32'(i > 0 && (i % 16) == 0));
            check("v16_onehot", 32'($countones(out2)), 32'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
